regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter DATA_W, default 32, SHALL set the register data width.
REQ-003 Parameter ADDR_W, default 5, SHALL set the register address width; depth is 2**ADDR_W.
REQ-004 Parameter NUM_RD, default 3, SHALL set the number of read ports (range 1..4).
REQ-005 Ports SHALL be:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, 1 = reset active
we0  in  1  write port 0 enable
waddr0  in  ADDR_W  write port 0 address
wdata0  in  DATA_W  write port 0 data
we1  in  1  write port 1 enable (higher priority)
waddr1  in  ADDR_W  write port 1 address
wdata1  in  DATA_W  write port 1 data
re  in  NUM_RD  per-port read enable
raddr  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
rdata  out  NUM_RD*DATA_W  read data, same packing
iss_valid  in  1  a producer to register iss_addr is issued this cycle
iss_addr  in  ADDR_W  destination of the issued producer
busy_hit  out  NUM_RD  read port i targets a register with a pending producer

Function
REQ-006 Register 0 SHALL read as zero and SHALL never be written or marked busy.
REQ-007 Writes SHALL take effect at the rising edge when wen=1, waddr!=0 and rst=0.
REQ-008 When both write ports target the same nonzero address in one cycle, the register SHALL take wdata1.
REQ-009 Reads SHALL be combinational (zero-cycle latency).
REQ-010 Read port i priority SHALL be: rst=1 -> 0; raddr=0 -> 0; re[i]=0 -> 0; we1 and waddr1=raddr -> wdata1; we0 and waddr0=raddr -> wdata0; else the stored value.
REQ-011 A busy bit per register SHALL be set at the edge when iss_valid=1 and iss_addr!=0.
REQ-012 A busy bit SHALL be cleared at the edge when either write port writes that address.
REQ-013 When a set and a clear hit the same address in one cycle, set SHALL win.
REQ-014 busy_hit[i] SHALL be 1 only when re[i]=1, raddr!=0, the register's busy bit is 1, no enabled write port matches raddr this cycle, and rst=0.
REQ-015 busy_hit SHALL be combinational and SHALL NOT depend on iss_valid of the same cycle.
REQ-016 Write-port enables SHALL not depend on busy state; a write to a non-busy register is legal.

Reset
REQ-017 With rst=1 at an edge, all registers and all busy bits SHALL clear to 0, and writes and issues that cycle SHALL be ignored.
REQ-018 While rst=1, rdata and busy_hit SHALL be all-zero.
REQ-019 Reset asserted mid-operation SHALL discard pending busy state, with no residual forwarding after release.

Structure
REQ-020 Package regfile_pkg SHALL hold the default DATA_W and ADDR_W, the zero word, the NOP register address (0), and the enable-level constants.
REQ-021 One sub-module regfile_rdport (single read mux with two-level bypass and busy_hit) SHALL be instantiated NUM_RD times via generate.
REQ-022 The storage array and the busy vector SHALL reside in regfile_mp.

Verification
REQ-023 Write r5=0x1234 via port 0, then read on all ports next cycle -> every rdata = 0x00001234, busy_hit = 0.
REQ-024 Same cycle: we0 r7=0xAAAA and we1 r7=0x5555; read r7 on port 0 that cycle -> 0x5555; next cycle -> 0x5555 stored.
REQ-025 Write r0=0xFFFF and issue r0 -> r0 reads 0, busy_hit = 0 on every port.
REQ-026 Issue r3, then read r3 next cycle -> busy_hit[i] = 1; writeback r3=0x42 that cycle -> busy_hit = 0 and rdata = 0x42.
REQ-027 Issue r9 and write r9 in the same cycle -> busy stays 1 next cycle; with re=0 -> busy_hit = 0 and rdata = 0.
REQ-028 Load r1..r4 and set busy on r2, then pulse rst for one cycle -> all reads = 0 and busy_hit = 0 after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file.
//   DATA_W_DEF / ADDR_W_DEF : default data and address widths
//   ZERO_WORD               : value driven for r0 and for disabled/reset reads
//   NOP_REG                 : hard-wired zero register address
//   EN_ON / EN_OFF          : enable levels for write, read and issue controls
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;
  localparam int unsigned           NOP_REG   = 0;

  localparam logic EN_ON  = 1'b1;
  localparam logic EN_OFF = 1'b0;

endpackage : regfile_pkg

// File: rtl/regfile_rdport.sv
// One combinational read port with two-level write bypass and a busy
// (pending producer) indication.
//   rst                : synchronous reset level, forces outputs to zero
//   re, raddr          : read enable and read address
//   we0/waddr0/wdata0  : write port 0 (lower bypass priority)
//   we1/waddr1/wdata1  : write port 1 (higher bypass priority)
//   stored, busy       : array contents and busy bit at raddr
//   rdata, busy_hit    : read result and pending-producer flag
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] stored,
  input  logic              busy,
  output logic [DATA_W-1:0] rdata,
  output logic              busy_hit
);

  logic hit0;
  logic hit1;
  logic active;

  // raddr is nonzero whenever active is set, so a write to r0 can never hit.
  assign hit0   = (we0 == EN_ON) && (waddr0 == raddr);
  assign hit1   = (we1 == EN_ON) && (waddr1 == raddr);
  assign active = (rst == EN_OFF) && (re == EN_ON) && (raddr != ADDR_W'(NOP_REG));

  // Bypass mux: port 1 write, then port 0 write, then stored value.
  always_comb begin
    rdata    = DATA_W'(ZERO_WORD);
    busy_hit = 1'b0;
    if (active) begin
      if (hit1) begin
        rdata = wdata1;
      end else if (hit0) begin
        rdata = wdata0;
      end else begin
        rdata = stored;
      end
      // A same-cycle writeback satisfies the pending producer.
      busy_hit = busy && !hit0 && !hit1;
    end
  end

endmodule : regfile_rdport

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports (port 1 wins on collision),
// NUM_RD combinational read ports with write bypass, and a per-register
// busy scoreboard set by issue and cleared by writeback.
//   clk, rst                 : clock and synchronous active-high reset
//   we0/waddr0/wdata0        : write port 0
//   we1/waddr1/wdata1        : write port 1 (higher priority)
//   re, raddr, rdata         : packed read ports, port i at [i*W +: W]
//   iss_valid, iss_addr      : producer issue marking iss_addr busy
//   busy_hit                 : per read port, target has a pending producer
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NUM_RD = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [NUM_RD-1:0]        busy_hit
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic              wr0;
  logic              wr1;
  logic              iss;

  assign wr0 = (we0 == EN_ON) && (waddr0 != ADDR_W'(NOP_REG));
  assign wr1 = (we1 == EN_ON) && (waddr1 != ADDR_W'(NOP_REG));
  assign iss = (iss_valid == EN_ON) && (iss_addr != ADDR_W'(NOP_REG));

  // Busy update: writebacks clear, issue sets afterwards so set wins.
  always_comb begin
    busy_nxt = busy;
    if (wr0) busy_nxt[waddr0] = 1'b0;
    if (wr1) busy_nxt[waddr1] = 1'b0;
    if (iss) busy_nxt[iss_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Storage; port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        mem[ADDR_W'(k)] <= DATA_W'(ZERO_WORD);
      end
      busy <= '0;
    end else begin
      if (wr0) mem[waddr0] <= wdata0;
      if (wr1) mem[waddr1] <= wdata1;
      busy <= busy_nxt;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = raddr[i*ADDR_W +: ADDR_W];

    regfile_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_rdport (
      .rst      (rst),
      .re       (re[i]),
      .raddr    (ra),
      .we0      (we0),
      .waddr0   (waddr0),
      .wdata0   (wdata0),
      .we1      (we1),
      .waddr1   (waddr1),
      .wdata1   (wdata1),
      .stored   (mem[ra]),
      .busy     (busy[ra]),
      .rdata    (rdata[i*DATA_W +: DATA_W]),
      .busy_hit (busy_hit[i])
    );
  end

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: each stimulus cycle pushes the expected
// read response; a negedge monitor pops and compares.
module tb_regfile_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              we0, we1, iss_valid;
  logic [AW-1:0]     waddr0, waddr1, iss_addr;
  logic [DW-1:0]     wdata0, wdata1;
  logic [NR-1:0]     re;
  logic [NR*AW-1:0]  raddr;
  logic [NR*DW-1:0]  rdata;
  logic [NR-1:0]     busy_hit;

  typedef struct {
    string            name;
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]    bh;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .we0       (we0),
    .waddr0    (waddr0),
    .wdata0    (wdata0),
    .we1       (we1),
    .waddr1    (waddr1),
    .wdata1    (wdata1),
    .re        (re),
    .raddr     (raddr),
    .rdata     (rdata),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .busy_hit  (busy_hit)
  );

  function automatic logic [NR*DW-1:0] rd3(input logic [DW-1:0] p0, p1, p2);
    return {p2, p1, p0};
  endfunction

  function automatic logic [NR*AW-1:0] ra3(input int a0, a1, a2);
    return {AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  task automatic clear_inputs();
    rst = 1'b0; we0 = 1'b0; we1 = 1'b0; iss_valid = 1'b0;
    waddr0 = '0; waddr1 = '0; iss_addr = '0;
    wdata0 = '0; wdata1 = '0; re = '0; raddr = '0;
  endtask

  // Advance one cycle and drive defaults shortly after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic expect_out(input string name, input logic [NR*DW-1:0] rd,
                            input logic [NR-1:0] bh);
    exp_t e;
    e.name = name; e.rd = rd; e.bh = bh;
    exp_q.push_back(e);
  endtask

  // Monitor: compare combinational outputs mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      n_vec++;
      if (rdata !== cur.rd || busy_hit !== cur.bh) begin
        n_err++;
        $display("FAIL %s: rdata=%h busy_hit=%b, expected rdata=%h busy_hit=%b",
                 cur.name, rdata, busy_hit, cur.rd, cur.bh);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares",
             n_vec, n_err);
    $fatal(1);
  end

  initial begin
    clear_inputs();
    rst = 1'b1;

    // Reset: outputs forced to zero even with reads enabled.
    step(); rst = 1'b1; re = 3'b111; raddr = ra3(5, 5, 5);
    expect_out("reset_read", '0, 3'b000);
    step(); rst = 1'b1; re = 3'b111; raddr = ra3(1, 2, 3);
    expect_out("reset_read2", '0, 3'b000);

    // Write r5 via port 0, read on all ports next cycle.
    step(); we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h1234;
    expect_out("wr_r5_no_read", '0, 3'b000);
    step(); re = 3'b111; raddr = ra3(5, 5, 5);
    expect_out("rd_r5_all", rd3(32'h1234, 32'h1234, 32'h1234), 3'b000);

    // Dual write collision on r7: port 1 wins in bypass and in storage.
    step(); we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'hAAAA;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h5555;
    re = 3'b001; raddr = ra3(7, 7, 7);
    expect_out("collide_r7_bypass", rd3(32'h5555, 0, 0), 3'b000);
    step(); re = 3'b111; raddr = ra3(7, 7, 7);
    expect_out("collide_r7_stored", rd3(32'h5555, 32'h5555, 32'h5555), 3'b000);

    // r0 writes and issues are ignored.
    step(); we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFF;
    we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFF;
    iss_valid = 1'b1; iss_addr = 5'd0; re = 3'b111; raddr = ra3(0, 0, 0);
    expect_out("r0_write_bypass", '0, 3'b000);
    step(); re = 3'b111; raddr = ra3(0, 0, 0);
    expect_out("r0_after", '0, 3'b000);

    // Issue r3: busy not visible the same cycle.
    step(); iss_valid = 1'b1; iss_addr = 5'd3; re = 3'b111; raddr = ra3(3, 3, 3);
    expect_out("iss_r3_same_cycle", '0, 3'b000);
    step(); re = 3'b011; raddr = ra3(3, 3, 3);
    expect_out("r3_busy", '0, 3'b011);
    step(); we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h42;
    re = 3'b111; raddr = ra3(3, 3, 3);
    expect_out("r3_writeback", rd3(32'h42, 32'h42, 32'h42), 3'b000);
    step(); re = 3'b111; raddr = ra3(3, 3, 3);
    expect_out("r3_cleared", rd3(32'h42, 32'h42, 32'h42), 3'b000);

    // Issue and write r9 together: set wins.
    step(); iss_valid = 1'b1; iss_addr = 5'd9;
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h99;
    re = 3'b001; raddr = ra3(9, 9, 9);
    expect_out("r9_set_and_clear", rd3(32'h99, 0, 0), 3'b000);
    step(); re = 3'b101; raddr = ra3(9, 9, 9);
    expect_out("r9_still_busy", rd3(32'h99, 0, 32'h99), 3'b101);
    step(); re = 3'b000; raddr = ra3(9, 9, 9);
    expect_out("r9_re_off", '0, 3'b000);
    step(); we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h11;
    re = 3'b111; raddr = ra3(9, 9, 9);
    expect_out("r9_wb_port0", rd3(32'h11, 32'h11, 32'h11), 3'b000);
    step(); re = 3'b111; raddr = ra3(9, 9, 9);
    expect_out("r9_cleared", rd3(32'h11, 32'h11, 32'h11), 3'b000);

    // Independent writes on both ports, bypass per port.
    step(); we0 = 1'b1; waddr0 = 5'd10; wdata0 = 32'hA0A0_0001;
    we1 = 1'b1; waddr1 = 5'd11; wdata1 = 32'hB0B0_0002;
    re = 3'b111; raddr = ra3(10, 11, 12);
    expect_out("split_bypass", rd3(32'hA0A0_0001, 32'hB0B0_0002, 0), 3'b000);

    // Load r1..r4, mark r2 busy, then reset mid-operation.
    step(); we0 = 1'b1; waddr0 = 5'd1; wdata0 = 32'h101;
    we1 = 1'b1; waddr1 = 5'd2; wdata1 = 32'h202;
    expect_out("load_r1_r2", '0, 3'b000);
    step(); we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h303;
    we1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h404;
    iss_valid = 1'b1; iss_addr = 5'd2;
    expect_out("load_r3_r4_iss_r2", '0, 3'b000);
    step(); re = 3'b111; raddr = ra3(1, 2, 3);
    expect_out("loaded_r2_busy", rd3(32'h101, 32'h202, 32'h303), 3'b010);
    step(); re = 3'b111; raddr = ra3(10, 11, 4);
    expect_out("loaded_more", rd3(32'hA0A0_0001, 32'hB0B0_0002, 32'h404), 3'b000);
    step(); rst = 1'b1; we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'hDEAD;
    iss_valid = 1'b1; iss_addr = 5'd5; re = 3'b111; raddr = ra3(2, 4, 1);
    expect_out("reset_pulse", '0, 3'b000);
    step(); re = 3'b111; raddr = ra3(1, 2, 3);
    expect_out("post_reset_a", '0, 3'b000);
    step(); re = 3'b111; raddr = ra3(4, 5, 2);
    expect_out("post_reset_b", '0, 3'b000);

    step();
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_regfile_mp
